// File: rtl/m_w_wdata_pipe_pkg.sv
// Shared CPU defines for the M->W write-data path: wait-FSM states and
// the default write-data source select codes.
package m_w_wdata_pipe_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wstate_e;

  localparam logic [2:0] SEL_ANS    = 3'd0;
  localparam logic [2:0] SEL_RDATA  = 3'd1;
  localparam logic [2:0] SEL_ADDER  = 3'd2;
  localparam logic [2:0] SEL_HL     = 3'd3;
  localparam logic [2:0] SEL_RDATA2 = 3'd4;
  localparam logic [2:0] SEL_CP0    = 3'd5;

  // Even parity of a 5-bit register index.
  function automatic logic waddr_parity(input logic [4:0] a);
    return ^a;
  endfunction

endpackage

// File: rtl/m_w_wdata_pipe_src_sel.sv
// Combinational write-data source mux with link-offset adjust; also used by
// the E-stage forwarding path.
module wdata_src_sel #(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 6,
  parameter int SELW     = 3,
  parameter int LINK_IDX = 2,
  parameter int LINK_OFS = 4
) (
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_ready,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      data,
  output logic                  ok
);

  logic [SELW-1:0]  eff_sel_s;
  logic [WIDTH-1:0] raw_s;
  logic             rdy_s;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    if ({1'b0, sel} < (SELW+1)'(NSRC)) begin
      eff_sel_s = sel;
    end else begin
      eff_sel_s = '0;
    end
    raw_s = '0;
    rdy_s = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (eff_sel_s == SELW'(k)) begin
        raw_s = src_data[k*WIDTH +: WIDTH];
        rdy_s = src_ready[k];
      end else begin
        raw_s = raw_s;
        rdy_s = rdy_s;
      end
    end
    if (eff_sel_s == SELW'(LINK_IDX)) begin
      data = raw_s + WIDTH'(LINK_OFS);
    end else begin
      data = raw_s;
    end
    ok = in_valid & rdy_s;
  end

endmodule

// File: rtl/m_w_wdata_pipe.sv
// M->W write-data pipeline register: selects the write-back value, stalls
// while a late source is not ready, and flags a sticky timeout.
module m_w_wdata_pipe
  import m_w_wdata_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 6,
  parameter int SELW     = 3,
  parameter int LINK_IDX = 2,
  parameter int LINK_OFS = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_ready,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  input  logic [4:0]            in_waddr,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic [WIDTH-1:0]      fwd_data,
  output logic                  fwd_ok,
  output logic [WIDTH-1:0]      W_wdata,
  output logic [4:0]            W_waddr,
  output logic                  W_we,
  output logic                  stall_req,
  output logic                  timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  wstate_e       state_r, state_nx;
  logic [CW-1:0] cnt_r;
  logic          timeout_r;
  logic          enter_wait_s;
  logic          waiting_s;

  wdata_src_sel #(
    .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW),
    .LINK_IDX(LINK_IDX), .LINK_OFS(LINK_OFS)
  ) u_sel (
    .src_data (src_data),
    .src_ready(src_ready),
    .sel      (sel),
    .in_valid (in_valid),
    .data     (fwd_data),
    .ok       (fwd_ok)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state: flush beats stall_in, stall_in freezes, capture returns to RUN.
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = ST_RUN;
    end else if (stall_in) begin
      state_nx = state_r;
    end else if (fwd_ok) begin
      state_nx = ST_RUN;
    end else if (state_r == ST_RUN && in_valid) begin
      state_nx = ST_WAIT;
    end else begin
      state_nx = state_r;
    end
  end

  // Stall request output.
  always_comb begin
    case (state_r)
      ST_RUN:  stall_req = reset & in_valid & ~fwd_ok & ~flush;
      ST_WAIT: stall_req = reset & ~fwd_ok & ~flush;
      default: stall_req = 1'b0;
    endcase
  end

  assign enter_wait_s = (state_r == ST_RUN) && (state_nx == ST_WAIT);
  assign waiting_s    = (state_r == ST_WAIT) && !fwd_ok && !flush;

  // Wait counter saturates at MAX_WAIT; timeout latches once it gets there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else if (enter_wait_s) begin
      cnt_r <= '0;
    end else if (waiting_s) begin
      if (cnt_r < CW'(MAX_WAIT)) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (cnt_r >= CW'(MAX_WAIT - 1)) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout = timeout_r;

  // W-stage write registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_wdata <= '0;
      W_waddr <= 5'd0;
      W_we    <= 1'b0;
    end else if (flush) begin
      W_we <= 1'b0;
    end else if (stall_in) begin
      W_we <= W_we;
    end else if (fwd_ok) begin
      W_wdata <= fwd_data;
      W_waddr <= in_waddr;
      W_we    <= (in_waddr != 5'd0);
    end else begin
      W_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_m_w_wdata_pipe.sv
// Randomized scoreboard bench for m_w_wdata_pipe against a behavioural model.
module tb_m_w_wdata_pipe;
  localparam int WIDTH = 32, NSRC = 6, SELW = 3, LINK_IDX = 2, LINK_OFS = 4, MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NSRC*WIDTH-1:0] src_data = '0;
  logic [NSRC-1:0] src_ready = '0;
  logic [SELW-1:0] sel = '0;
  logic in_valid = 1'b0, stall_in = 1'b0, flush = 1'b0;
  logic [4:0] in_waddr = 5'd0;
  logic [WIDTH-1:0] fwd_data, W_wdata;
  logic fwd_ok, W_we, stall_req, timeout;
  logic [4:0] W_waddr;

  always #5 clk = ~clk;

  m_w_wdata_pipe dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_ready(src_ready), .sel(sel),
    .in_valid(in_valid), .in_waddr(in_waddr), .stall_in(stall_in), .flush(flush),
    .fwd_data(fwd_data), .fwd_ok(fwd_ok), .W_wdata(W_wdata), .W_waddr(W_waddr),
    .W_we(W_we), .stall_req(stall_req), .timeout(timeout)
  );

  typedef struct { logic [31:0] data; logic ok; logic stall; } comb_t;
  typedef struct { logic [31:0] wdata; logic [4:0] waddr; logic we; logic to; } regs_t;
  comb_t comb_q[$];
  regs_t regs_q[$];

  int checks = 0, passes = 0;

  // Model state: a pending wait with the count of cycles waited so far.
  logic        m_wait;
  int          m_cnt;
  logic        m_to, m_we;
  logic [31:0] m_wdata;
  logic [4:0]  m_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_cnt = 0; m_to = 1'b0; m_we = 1'b0; m_wdata = '0; m_waddr = 5'd0;
  endtask

  task automatic model_step();
    int eff;
    logic [31:0] val;
    logic ok, stl;
    comb_t c;
    regs_t r;
    eff = (int'(sel) < NSRC) ? int'(sel) : 0;
    val = src_data[eff*WIDTH +: WIDTH];
    if (eff == LINK_IDX) val = val + 32'(LINK_OFS);
    ok  = in_valid && src_ready[eff];
    stl = !flush && !ok && (m_wait || in_valid);
    c.data = val; c.ok = ok; c.stall = stl;
    comb_q.push_back(c);
    if (flush) begin
      m_we = 1'b0; m_wait = 1'b0;
    end else begin
      if (m_wait && !ok) begin
        m_cnt = (m_cnt < MAX_WAIT) ? m_cnt + 1 : MAX_WAIT;
        if (m_cnt >= MAX_WAIT) m_to = 1'b1;
      end
      if (!stall_in) begin
        if (ok) begin
          m_wdata = val; m_waddr = in_waddr; m_we = (in_waddr != 5'd0); m_wait = 1'b0;
        end else begin
          m_we = 1'b0;
          if (!m_wait && in_valid) begin m_wait = 1'b1; m_cnt = 0; end
        end
      end
    end
    r.wdata = m_wdata; r.waddr = m_waddr; r.we = m_we; r.to = m_to;
    regs_q.push_back(r);
  endtask

  task automatic drive(input logic [2:0] s, input logic [5:0] rdy, input logic v,
                       input logic [4:0] a, input logic st, input logic fl,
                       input logic [NSRC*WIDTH-1:0] d);
    @(posedge clk); #2;
    sel = s; src_ready = rdy; in_valid = v; in_waddr = a; stall_in = st; flush = fl; src_data = d;
    model_step();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    in_valid = 1'b1; src_ready = 6'b000000; flush = 1'b0; stall_in = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_wdata", W_wdata, 32'h0);
    check("rst_waddr", {27'd0, W_waddr}, 32'h0);
    check("rst_we", {31'd0, W_we}, 32'h0);
    check("rst_timeout", {31'd0, timeout}, 32'h0);
    check("rst_stall_req", {31'd0, stall_req}, 32'h0);
    model_reset();
    @(posedge clk); #2;
    in_valid = 1'b0;
    reset = 1'b1;
  endtask

  function automatic logic [NSRC*WIDTH-1:0] rand_src();
    logic [NSRC*WIDTH-1:0] d;
    for (int k = 0; k < NSRC; k++) d[k*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  // Combinational monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (comb_q.size() > 0) begin
      comb_t c;
      c = comb_q.pop_front();
      check("fwd_data", fwd_data, c.data);
      check("fwd_ok", {31'd0, fwd_ok}, {31'd0, c.ok});
      check("stall_req", {31'd0, stall_req}, {31'd0, c.stall});
    end
  end

  // Register monitor, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (regs_q.size() > 0) begin
      regs_t r;
      r = regs_q.pop_front();
      check("W_wdata", W_wdata, r.wdata);
      check("W_waddr", {27'd0, W_waddr}, {27'd0, r.waddr});
      check("W_we", {31'd0, W_we}, {31'd0, r.we});
      check("timeout", {31'd0, timeout}, {31'd0, r.to});
    end
  end

  initial begin
    logic [NSRC*WIDTH-1:0] d;
    model_reset();
    do_reset();

    // Link offset on source 2.
    d = rand_src(); d[2*WIDTH +: WIDTH] = 32'h0000_3000;
    drive(3'd2, 6'h3f, 1'b1, 5'd31, 1'b0, 1'b0, d);
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, d);
    check("link_wdata", W_wdata, 32'h0000_3004);
    check("link_waddr", {27'd0, W_waddr}, 32'd31);
    check("link_we", {31'd0, W_we}, 32'd1);

    // Late source 1: three stalled cycles, then ready.
    d = rand_src(); d[1*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) drive(3'd1, 6'b111101, 1'b1, 5'd7, 1'b0, 1'b0, d);
    drive(3'd1, 6'h3f, 1'b1, 5'd7, 1'b0, 1'b0, d);
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, d);
    check("late_wdata", W_wdata, 32'hDEAD_BEEF);

    // Out-of-range select falls back to source 0.
    d = rand_src(); d[31:0] = 32'h1234_5678;
    drive(3'd6, 6'h3f, 1'b1, 5'd3, 1'b0, 1'b0, d);
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, d);
    check("oor_wdata", W_wdata, 32'h1234_5678);

    // Wait on source 5 killed by flush.
    for (int i = 0; i < 2; i++) drive(3'd5, 6'b011111, 1'b1, 5'd9, 1'b0, 1'b0, d);
    drive(3'd5, 6'b011111, 1'b1, 5'd9, 1'b0, 1'b1, d);
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, d);

    // waddr 0 never writes; stall_in holds a capture.
    drive(3'd0, 6'h3f, 1'b1, 5'd0, 1'b0, 1'b0, d);
    d = rand_src();
    for (int i = 0; i < 3; i++) drive(3'd4, 6'h3f, 1'b1, 5'd12, 1'b1, 1'b0, d);
    drive(3'd4, 6'h3f, 1'b1, 5'd12, 1'b0, 1'b0, d);
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, d);

    // Source 1 never ready: timeout after MAX_WAIT wait cycles, sticky.
    for (int i = 0; i < MAX_WAIT + 6; i++) drive(3'd1, 6'b111101, 1'b1, 5'd5, 1'b0, 1'b0, d);
    drive(3'd0, 6'h3f, 1'b1, 5'd5, 1'b0, 1'b0, d);
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, d);
    check("timeout_sticky", {31'd0, timeout}, 32'd1);
    do_reset();

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      logic [5:0] rdy;
      for (int k = 0; k < NSRC; k++) rdy[k] = ($urandom_range(3, 0) != 0);
      if (n % 400 == 399) do_reset();
      drive(3'($urandom_range(7, 0)), rdy, ($urandom_range(3, 0) != 0),
            ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(7, 0) == 0), ($urandom_range(15, 0) == 0), rand_src());
    end
    drive(3'd0, 6'h3f, 1'b0, 5'd0, 1'b0, 1'b0, '0);
    @(posedge clk); #3;
    checks++;
    if (comb_q.size() == 0 && regs_q.size() == 0) passes++;
    else $display("FAIL drain: comb_q %0d regs_q %0d left, required 0", comb_q.size(), regs_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/m_w_wdata_pipe.md
M_W_WDATA_PIPE -- requirements
Module: m_w_wdata_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width.
REQ-002 SHALL have parameter NSRC, default 6, number of write-data sources.
REQ-003 SHALL have parameter SELW, default 3, select width.
REQ-004 SHALL have parameter LINK_IDX, default 2, source index receiving link offset.
REQ-005 SHALL have parameter LINK_OFS, default 4, constant added to source LINK_IDX.
REQ-006 SHALL have parameter MAX_WAIT, default 15, wait-cycle limit before timeout.
REQ-007 SHALL have port clk  in  1  clock, rising edge.
REQ-008 SHALL have port reset  in  1  one clock; reset is asynchronous and active-low.
REQ-009 SHALL have port src_data  in  NSRC*WIDTH  packed sources, source k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port src_ready  in  NSRC  per-source data-valid (late sources, e.g. slow load/CP0).
REQ-011 SHALL have port sel  in  SELW  source select.
REQ-012 SHALL have port in_valid  in  1  M-stage instruction writes GRF.
REQ-013 SHALL have port in_waddr  in  5  destination register.
REQ-014 SHALL have port stall_in  in  1  downstream hold.
REQ-015 SHALL have port flush  in  1  kill M-stage instruction.
REQ-016 SHALL have ports fwd_data  out  WIDTH  and fwd_ok  out  1: combinational selected value and its readiness, for M-stage forwarding.
REQ-017 SHALL have ports W_wdata  out  WIDTH, W_waddr  out  5, W_we  out  1: registered W-stage write.
REQ-018 SHALL have ports stall_req  out  1  pipeline hold request, and timeout  out  1  sticky error.

Function
REQ-019 SHALL select source sel when sel < NSRC, else source 0.
REQ-020 SHALL add LINK_OFS (modulo 2^WIDTH) to the selected value only when effective select equals LINK_IDX.
REQ-021 SHALL drive fwd_ok = in_valid & src_ready[effective select].
REQ-022 SHALL have states RUN and WAIT.
REQ-023 In RUN, in_valid & !fwd_ok & !flush SHALL move to WAIT, clear wait counter, assert stall_req combinationally that cycle.
REQ-024 In WAIT, stall_req SHALL stay 1 until fwd_ok; wait counter increments per cycle, saturating at MAX_WAIT.
REQ-025 Counter reaching MAX_WAIT SHALL set timeout (sticky until reset) and keep waiting.
REQ-026 Capture SHALL occur on an edge where fwd_ok & !stall_in & !flush: W_wdata<=fwd_data, W_waddr<=in_waddr, W_we<=(in_waddr!=0); state -> RUN.
REQ-027 Latency SHALL be one cycle from capture edge to W_we visible.
REQ-028 stall_in=1 SHALL hold all W_* registers and state unchanged (flush excepted).
REQ-029 flush SHALL take priority over stall_in, capture and WAIT: W_we<=0 next edge, state -> RUN, stall_req deasserted that cycle.
REQ-030 Edge with !in_valid (no flush, no stall_in) SHALL write W_we<=0; W_wdata/W_waddr unchanged.
REQ-031 in_waddr=0 SHALL never produce W_we=1.

Reset
REQ-032 reset low SHALL asynchronously force W_wdata=0, W_waddr=0, W_we=0, state RUN, counter 0, timeout 0.
REQ-033 Reset asserted during WAIT SHALL abort the wait with no write.
REQ-034 stall_req SHALL be 0 while reset is low.

Structure
REQ-035 State encoding and default select codes (ANS=0, RDATA=1, ADDER=2, HL=3, RDATA2=4, CP0=5) SHALL live in the shared CPU define package.
REQ-036 Combinational selection SHALL be one sub-module, wdata_src_sel, reused by the E-stage forwarding path.

Verification
REQ-037 sel=2, src2=0x00003000, all ready, in_valid, waddr=31 -> next cycle W_wdata=0x00003004, W_waddr=31, W_we=1.
REQ-038 sel=1, src_ready[1]=0 for 3 cycles then 1, data 0xDEADBEEF -> stall_req=1 exactly 3 cycles, W_wdata=0xDEADBEEF one edge after ready.
REQ-039 sel=6 (out of range), src0=0x12345678 -> W_wdata=0x12345678.
REQ-040 WAIT on source 5 with flush pulse -> W_we=0 next cycle, stall_req=0, state RUN.
REQ-041 source 1 never ready, MAX_WAIT=15 -> timeout=1 after 15 wait cycles, stays 1 until reset low.
REQ-042 waddr=0 valid write -> W_we=0; stall_in=1 during capture -> W_* held until release.
